id_stage_pipe: RTL and testbench

- Registered, parametrised RV32I decode stage with valid/ready handshake to IF and EX.
- Decodes OP-IMM, OP, LUI and AUIPC, and drives register-file read ports.
- Resolves operands with EX/MEM forwarding, inserts load-use bubbles, honours flush, and holds results in an ID/EX output register.
- Sits between the instruction-fetch buffer and the execute stage.

---
 rtl/id_stage_pipe.sv | 231 +++++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: registered RV32I decode stage (OP-IMM/OP/LUI/AUIPC)
// with EX/MEM operand forwarding, load-use stall and ID/EX register.
module id_stage_pipe #(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int ALUSEL_W = 3,
  parameter int ALUOP_W  = 8,
  parameter bit FWD_EN   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [31:0]         in_inst,
  output logic                re1,
  output logic                re2,
  output logic [REG_AW-1:0]   raddr1,
  output logic [REG_AW-1:0]   raddr2,
  input  logic [XLEN-1:0]     rdata1,
  input  logic [XLEN-1:0]     rdata2,
  input  logic                ex_we,
  input  logic [REG_AW-1:0]   ex_waddr,
  input  logic [XLEN-1:0]     ex_wdata,
  input  logic                ex_is_load,
  input  logic                mem_we,
  input  logic [REG_AW-1:0]   mem_waddr,
  input  logic [XLEN-1:0]     mem_wdata,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [ALUSEL_W-1:0] alusel,
  output logic [ALUOP_W-1:0]  aluop,
  output logic                we,
  output logic [REG_AW-1:0]   waddr,
  output logic [XLEN-1:0]     opv1,
  output logic [XLEN-1:0]     opv2,
  output logic                illegal
);

  localparam logic [ALUSEL_W-1:0] S_NOP   = ALUSEL_W'(0);
  localparam logic [ALUSEL_W-1:0] S_LOGIC = ALUSEL_W'(1);
  localparam logic [ALUSEL_W-1:0] S_SHIFT = ALUSEL_W'(2);
  localparam logic [ALUSEL_W-1:0] S_ARITH = ALUSEL_W'(3);

  localparam logic [ALUOP_W-1:0] O_NOP  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] O_ADD  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] O_SLT  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] O_SLTU = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] O_XOR  = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] O_OR   = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] O_AND  = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] O_SLL  = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] O_SRL  = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] O_SRA  = ALUOP_W'(9);
  localparam logic [ALUOP_W-1:0] O_SUB  = ALUOP_W'(10);

  logic [6:0]        opc, f7;
  logic [2:0]        f3;
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic              is_opimm, is_op, is_lui, is_auipc, alt;
  logic [XLEN-1:0]   imm_i, imm_u, shamt;

  assign opc      = in_inst[6:0];
  assign f3       = in_inst[14:12];
  assign f7       = in_inst[31:25];
  assign rd       = REG_AW'(in_inst[11:7]);
  assign rs1      = REG_AW'(in_inst[19:15]);
  assign rs2      = REG_AW'(in_inst[24:20]);
  assign is_opimm = (opc == 7'h13);
  assign is_op    = (opc == 7'h33);
  assign is_lui   = (opc == 7'h37);
  assign is_auipc = (opc == 7'h17);
  assign alt      = (f7 == 7'h20);
  assign imm_i    = XLEN'($signed(in_inst[31:20]));
  assign imm_u    = XLEN'($signed({in_inst[31:12], 12'h000}));
  assign shamt    = XLEN'(in_inst[24:20]);
  assign raddr1   = rs1;
  assign raddr2   = rs2;

  logic [ALUSEL_W-1:0] sel_d;
  logic [ALUOP_W-1:0]  op_d;
  logic                ill_d, we_d, pc_src;
  logic [XLEN-1:0]     imm_d, opv1_d, opv2_d;

  always_comb begin
    sel_d  = S_NOP;
    op_d   = O_NOP;
    ill_d  = 1'b0;
    re1    = 1'b0;
    re2    = 1'b0;
    imm_d  = '0;
    pc_src = 1'b0;
    unique case (1'b1)
      is_opimm: begin
        re1   = 1'b1;
        imm_d = (f3 == 3'd1 || f3 == 3'd5) ? shamt : imm_i;
        ill_d = (f3 == 3'd1 && f7 != 7'h00) ||
                (f3 == 3'd5 && f7 != 7'h00 && !alt);
      end
      is_op: begin
        re1   = 1'b1;
        re2   = 1'b1;
        ill_d = f7 != 7'h00 && !(alt && (f3 == 3'd0 || f3 == 3'd5));
      end
      is_lui:   imm_d = imm_u;
      is_auipc: begin
        imm_d  = imm_u;
        pc_src = 1'b1;
      end
      default:  ill_d = 1'b1;
    endcase
    if (is_opimm || is_op) begin
      // funct3 picks the op; alt (funct7=0x20) only flips ADD->SUB on OP
      unique case (f3)
        3'd0: begin
          sel_d = S_ARITH;
          op_d  = (is_op && alt) ? O_SUB : O_ADD;
        end
        3'd1: begin sel_d = S_SHIFT; op_d = O_SLL;  end
        3'd2: begin sel_d = S_ARITH; op_d = O_SLT;  end
        3'd3: begin sel_d = S_ARITH; op_d = O_SLTU; end
        3'd4: begin sel_d = S_LOGIC; op_d = O_XOR;  end
        3'd5: begin
          sel_d = S_SHIFT;
          op_d  = alt ? O_SRA : O_SRL;
        end
        3'd6: begin sel_d = S_LOGIC; op_d = O_OR;   end
        3'd7: begin sel_d = S_LOGIC; op_d = O_AND;  end
      endcase
    end else if (is_lui || is_auipc) begin
      sel_d = S_ARITH;
      op_d  = O_ADD;
    end
    if (ill_d) begin
      sel_d  = S_NOP;
      op_d   = O_NOP;
      re1    = 1'b0;
      re2    = 1'b0;
      imm_d  = '0;
      pc_src = 1'b0;
    end
  end

  assign we_d = !ill_d && (rd != '0);

  function automatic logic [XLEN-1:0] resolve(
    input logic [REG_AW-1:0] a,
    input logic [XLEN-1:0]   rf,
    input logic              exw,
    input logic              exl,
    input logic [REG_AW-1:0] exa,
    input logic [XLEN-1:0]   exd,
    input logic              mw,
    input logic [REG_AW-1:0] ma,
    input logic [XLEN-1:0]   md
  );
    if (a == '0) return '0;
    if (FWD_EN && exw && !exl && exa == a) return exd;
    if (FWD_EN && mw && ma == a) return md;
    return rf;
  endfunction

  assign opv1_d = re1 ? resolve(rs1, rdata1, ex_we, ex_is_load, ex_waddr,
                                ex_wdata, mem_we, mem_waddr, mem_wdata)
                      : (pc_src ? in_pc : '0);
  assign opv2_d = re2 ? resolve(rs2, rdata2, ex_we, ex_is_load, ex_waddr,
                                ex_wdata, mem_we, mem_waddr, mem_wdata)
                      : imm_d;

  logic hz1, hz2, hz, adv, acc;

  // without forwarding any pending EX/MEM write to a source must wait
  assign hz1 = re1 && rs1 != '0 &&
               ((ex_we && ex_waddr == rs1 && (ex_is_load || !FWD_EN)) ||
                (!FWD_EN && mem_we && mem_waddr == rs1));
  assign hz2 = re2 && rs2 != '0 &&
               ((ex_we && ex_waddr == rs2 && (ex_is_load || !FWD_EN)) ||
                (!FWD_EN && mem_we && mem_waddr == rs2));
  assign hz  = hz1 || hz2;

  logic                valid_q, we_q, ill_q;
  logic [XLEN-1:0]     pc_q, opv1_q, opv2_q;
  logic [ALUSEL_W-1:0] sel_q;
  logic [ALUOP_W-1:0]  op_q;
  logic [REG_AW-1:0]   waddr_q;

  assign adv      = out_ready || !valid_q;
  assign in_ready = adv && !hz && !flush;
  assign acc      = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      sel_q   <= '0;
      op_q    <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      opv1_q  <= '0;
      opv2_q  <= '0;
      ill_q   <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (acc) begin
      valid_q <= 1'b1;
      pc_q    <= in_pc;
      sel_q   <= sel_d;
      op_q    <= op_d;
      we_q    <= we_d;
      waddr_q <= rd;
      opv1_q  <= opv1_d;
      opv2_q  <= opv2_d;
      ill_q   <= ill_d;
    end else if (adv) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_pc    = pc_q;
  assign alusel    = sel_q;
  assign aluop     = op_q;
  assign we        = we_q;
  assign waddr     = waddr_q;
  assign opv1      = opv1_q;
  assign opv2      = opv2_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed + random bench for id_stage_pipe
// against a mnemonic-level decode/forwarding reference model.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_inst;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        ex_we, ex_is_load, mem_we;
  logic [4:0]  ex_waddr, mem_waddr;
  logic [31:0] ex_wdata, mem_wdata;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_pc;
  logic [2:0]  alusel;
  logic [7:0]  aluop;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] opv1, opv2;
  logic        illegal;

  always #5 clk = ~clk;

  id_stage_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst),
    .re1(re1), .re2(re2), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2),
    .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
    .ex_is_load(ex_is_load),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .alusel(alusel), .aluop(aluop), .we(we), .waddr(waddr),
    .opv1(opv1), .opv2(opv2), .illegal(illegal)
  );

  typedef struct {
    logic [2:0]  sel;
    logic [7:0]  op;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] v1, v2;
    logic        ill, r1, r2;
  } dec_t;

  int nvec = 0;
  int nerr = 0;

  logic        e_valid;
  logic [31:0] e_pc;
  dec_t        e;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] src(input logic [4:0] a,
                                      input logic [31:0] rf);
    if (a == 5'd0) return 32'd0;
    if (ex_we && !ex_is_load && ex_waddr == a) return ex_wdata;
    if (mem_we && mem_waddr == a) return mem_wdata;
    return rf;
  endfunction

  function automatic dec_t model(input logic [31:0] inst,
                                 input logic [31:0] pc,
                                 input logic [31:0] rd1,
                                 input logic [31:0] rd2);
    string base[8] = '{"ADD","SLL","SLT","SLTU","XOR","SRL","OR","AND"};
    string opn[11] = '{"NOP","ADD","SLT","SLTU","XOR","OR","AND",
                       "SLL","SRL","SRA","SUB"};
    dec_t d;
    string m;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    opc = inst[6:0];
    f7  = inst[31:25];
    f3  = inst[14:12];
    d = '{default: '0};
    d.wa = inst[11:7];
    m = "ILL";
    if (opc == 7'h13) begin
      m = base[f3];
      if (f3 == 3'd1 && f7 != 7'h00) m = "ILL";
      if (f3 == 3'd5)
        m = (f7 == 7'h00) ? "SRL" : (f7 == 7'h20) ? "SRA" : "ILL";
      d.r1 = 1'b1;
      d.v1 = src(inst[19:15], rd1);
      if (f3 == 3'd1 || f3 == 3'd5) d.v2 = {27'd0, inst[24:20]};
      else d.v2 = {{20{inst[31]}}, inst[31:20]};
    end else if (opc == 7'h33) begin
      if (f7 == 7'h00) m = base[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) m = "SUB";
      else if (f7 == 7'h20 && f3 == 3'd5) m = "SRA";
      d.r1 = 1'b1;
      d.r2 = 1'b1;
      d.v1 = src(inst[19:15], rd1);
      d.v2 = src(inst[24:20], rd2);
    end else if (opc == 7'h37 || opc == 7'h17) begin
      m = "ADD";
      d.v1 = (opc == 7'h17) ? pc : 32'd0;
      d.v2 = {inst[31:12], 12'd0};
    end
    if (m == "ILL") begin
      d.ill = 1'b1;
      d.r1  = 1'b0;
      d.r2  = 1'b0;
    end else begin
      for (int i = 0; i < 11; i++) if (opn[i] == m) d.op = 8'(i);
      if (m == "XOR" || m == "OR" || m == "AND") d.sel = 3'd1;
      else if (m == "SLL" || m == "SRL" || m == "SRA") d.sel = 3'd2;
      else d.sel = 3'd3;
      d.we = (inst[11:7] != 5'd0);
    end
    return d;
  endfunction

  function automatic logic load_use(input dec_t d, input logic [31:0] inst);
    logic [4:0] a1, a2;
    a1 = inst[19:15];
    a2 = inst[24:20];
    return ex_we && ex_is_load &&
           ((d.r1 && a1 != 5'd0 && ex_waddr == a1) ||
            (d.r2 && a2 != 5'd0 && ex_waddr == a2));
  endfunction

  task automatic check_out();
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    if (e_valid) begin
      chk("out_pc", out_pc, e_pc);
      chk("alusel", 32'(alusel), 32'(e.sel));
      chk("aluop", 32'(aluop), 32'(e.op));
      chk("we", 32'(we), 32'(e.we));
      chk("waddr", 32'(waddr), 32'(e.wa));
      chk("illegal", 32'(illegal), 32'(e.ill));
      if (!e.ill) begin
        chk("opv1", opv1, e.v1);
        chk("opv2", opv2, e.v2);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_pc"}, out_pc, 32'd0);
    chk({tag, "_alusel"}, 32'(alusel), 32'd0);
    chk({tag, "_aluop"}, 32'(aluop), 32'd0);
    chk({tag, "_we"}, 32'(we), 32'd0);
    chk({tag, "_waddr"}, 32'(waddr), 32'd0);
    chk({tag, "_opv1"}, opv1, 32'd0);
    chk({tag, "_opv2"}, opv2, 32'd0);
    chk({tag, "_illegal"}, 32'(illegal), 32'd0);
  endtask

  // one cycle: check combinational handshake, clock, check ID/EX register
  task automatic step();
    dec_t d;
    logic hz, adv, acc;
    #1;
    d   = model(in_inst, in_pc, rdata1, rdata2);
    hz  = load_use(d, in_inst);
    adv = out_ready || !e_valid;
    acc = in_valid && adv && !hz && !flush;
    chk("in_ready", 32'(in_ready), 32'(adv && !hz && !flush));
    chk("raddr1", 32'(raddr1), 32'(in_inst[19:15]));
    chk("raddr2", 32'(raddr2), 32'(in_inst[24:20]));
    if (!d.ill) begin
      chk("re1", 32'(re1), 32'(d.r1));
      chk("re2", 32'(re2), 32'(d.r2));
    end
    @(posedge clk);
    if (flush) e_valid = 1'b0;
    else if (acc) begin
      e_valid = 1'b1;
      e_pc    = in_pc;
      e       = d;
    end else if (adv) e_valid = 1'b0;
    #1;
    check_out();
  endtask

  function automatic logic [31:0] gen();
    int k;
    logic [6:0] f7, opc;
    k = int'($urandom_range(0, 9));
    case ($urandom_range(0, 5))
      0, 1, 2, 3: f7 = 7'h00;
      4:          f7 = 7'h20;
      default:    f7 = 7'($urandom);
    endcase
    if (k < 4) opc = 7'h13;
    else if (k < 7) opc = 7'h33;
    else if (k == 7) opc = 7'h37;
    else if (k == 8) opc = 7'h17;
    else return $urandom;
    return {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), opc};
  endfunction

  task automatic quiet();
    ex_we = 0; ex_is_load = 0; ex_waddr = 0; ex_wdata = 0;
    mem_we = 0; mem_waddr = 0; mem_wdata = 0; flush = 0;
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 0; out_ready = 0; in_pc = 0; in_inst = 0;
    rdata1 = 0; rdata2 = 0;
    quiet();
    e_valid = 1'b0;
    e_pc = 0;
    e = '{default: '0};
    #12;
    check_zero("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    in_valid = 1; out_ready = 1;
    in_pc = 32'h100; in_inst = 32'h0F00E193; rdata1 = 32'h12345600;
    step();
    chk("ori_alusel", 32'(alusel), 32'd1);
    chk("ori_aluop", 32'(aluop), 32'd5);
    chk("ori_waddr", 32'(waddr), 32'd3);
    chk("ori_opv1", opv1, 32'h12345600);
    chk("ori_opv2", opv2, 32'h000000F0);

    in_pc = 32'h104; in_inst = 32'hFFF00293;
    step();
    chk("addi_opv1", opv1, 32'd0);
    chk("addi_opv2", opv2, 32'hFFFFFFFF);
    chk("addi_aluop", 32'(aluop), 32'd1);

    in_pc = 32'h108; in_inst = 32'h123453B7;
    step();
    chk("lui_opv2", opv2, 32'h12345000);

    in_pc = 32'h10C; in_inst = 32'h00208233;
    rdata1 = 32'h11111111; rdata2 = 32'h22222222;
    ex_we = 1; ex_waddr = 1; ex_wdata = 32'hAAAA0000;
    mem_we = 1; mem_waddr = 2; mem_wdata = 32'h5555;
    step();
    chk("fwd_opv1", opv1, 32'hAAAA0000);
    chk("fwd_opv2", opv2, 32'h00005555);

    in_pc = 32'h110; ex_is_load = 1; ex_waddr = 2;
    step();
    chk("lu_bubble", 32'(out_valid), 32'd0);
    ex_is_load = 0;
    step();
    chk("lu_resume", 32'(out_valid), 32'd1);

    quiet();
    out_ready = 0; in_pc = 32'h114; in_inst = 32'h0F00E193;
    for (int i = 0; i < 3; i++) step();
    chk("bp_hold_pc", out_pc, 32'h110);
    out_ready = 1;
    step();
    chk("bp_next_pc", out_pc, 32'h114);

    flush = 1; in_pc = 32'h118;
    step();
    chk("flush_valid", 32'(out_valid), 32'd0);
    flush = 0;

    for (int n = 0; n < 400; n++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 11) == 0);
      in_pc      = $urandom & 32'hFFFF_FFFC;
      in_inst    = gen();
      rdata1     = $urandom;
      rdata2     = $urandom;
      ex_we      = 1'($urandom_range(0, 1));
      ex_waddr   = 5'($urandom_range(0, 7));
      ex_wdata   = $urandom;
      ex_is_load = ($urandom_range(0, 5) == 0);
      mem_we     = 1'($urandom_range(0, 1));
      mem_waddr  = 5'($urandom_range(0, 7));
      mem_wdata  = $urandom;
      step();
    end

    quiet();
    in_valid = 1; out_ready = 1;
    in_pc = 32'h200; in_inst = 32'h0F00E193; rdata1 = 32'h12345600;
    step();
    #2;
    rst = 1'b0;
    #1;
    check_zero("async_rst");
    e_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
